// File: rtl/placar_pkg.sv
// Shared types, segment patterns and helpers for the placar_hex score keeper.
package placar_pkg;

   typedef enum logic [1:0] {
      JOGANDO      = 2'd0,
      INVULNERAVEL = 2'd1,
      PERDEU       = 2'd2
   } estado_t;

   // Active-low segments ordered {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;

   function automatic bit parametros_ok(input int vidas, input int pontos,
                                        input int invuln, input int pisca);
      return (vidas >= 1) && (vidas <= 9) && (pontos >= 1) && (pontos <= 9) &&
             (invuln >= 2) && (pisca >= 1);
   endfunction

   // Four-digit BCD add; a carry out of the thousands digit pins the result at 9999.
   function automatic logic [15:0] bcd_soma_sat(input logic [15:0] atual, input logic [3:0] inc);
      logic [15:0] res;
      logic [4:0]  soma;
      logic [3:0]  vai;
      res = '0;
      vai = inc;
      for (int i = 0; i < 4; i++) begin
         soma = {1'b0, atual[4*i +: 4]} + {1'b0, vai};
         if (soma > 5'd9) begin
            res[4*i +: 4] = 4'(soma - 5'd10);
            vai = 4'd1;
         end else begin
            res[4*i +: 4] = soma[3:0];
            vai = 4'd0;
         end
      end
      if (vai != 4'd0)
         res = 16'h9999;
      return res;
   endfunction

endpackage

// File: rtl/placar_hex_if.sv
// Event inputs from the entities stage and the score/lives status returned to it and to tela.
interface placar_hex_if;
   logic        pausa;
   logic        acerto_inimigo;
   logic        acerto_nave;
   logic [15:0] pontos;
   logic [3:0]  vidas;
   logic        perdeu;
   logic        invulneravel;

   modport master (
      output pausa, acerto_inimigo, acerto_nave,
      input  pontos, vidas, perdeu, invulneravel
   );

   modport slave (
      input  pausa, acerto_inimigo, acerto_nave,
      output pontos, vidas, perdeu, invulneravel
   );
endinterface

// File: rtl/bcd_para_7seg.sv
// Combinational BCD digit to active-low seven-segment decoder; non-decimal codes blank the digit.
module bcd_para_7seg
   import placar_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/placar_hex.sv
// Score, lives and game-over keeper driving six seven-segment displays.
// Optional game-over display blink is enabled by defining PLACAR_PISCA_EN.
module placar_hex
   import placar_pkg::*;
#(
   parameter int VIDAS_INICIAIS    = 3,
   parameter int PONTOS_POR_ACERTO = 1,
   parameter int INVULN_CICLOS     = 50_000_000,
   parameter int PISCA_CICLOS      = 12_500_000
) (
   input  logic         CLOCK_50,
   input  logic         reset,
   placar_hex_if.slave  bus,
   output logic [6:0]   HEX0,
   output logic [6:0]   HEX1,
   output logic [6:0]   HEX2,
   output logic [6:0]   HEX3,
   output logic [6:0]   HEX4,
   output logic [6:0]   HEX5
);

   localparam int             TW         = $clog2(INVULN_CICLOS);
   localparam logic [TW-1:0]  TIMER_INI  = TW'(INVULN_CICLOS - 1);
   localparam logic [3:0]     VIDAS_INI  = 4'(VIDAS_INICIAIS);
   localparam logic [3:0]     PONTOS_INC = 4'(PONTOS_POR_ACERTO);

   generate
      if (!parametros_ok(VIDAS_INICIAIS, PONTOS_POR_ACERTO, INVULN_CICLOS, PISCA_CICLOS)) begin : g_param_ilegal
         $error("placar_hex: parameter out of legal range");
      end
   endgenerate

   estado_t         estado_reg, estado_next;
   logic [15:0]     pontos_reg, pontos_next;
   logic [3:0]      vidas_reg, vidas_next;
   logic [TW-1:0]   timer_reg, timer_next;
   logic            inimigo_q_reg, nave_q_reg;
   logic            ev_inimigo, ev_nave;
   logic            apagar;

   assign ev_inimigo = bus.acerto_inimigo & ~inimigo_q_reg;
   assign ev_nave    = bus.acerto_nave & ~nave_q_reg;

   // Edge registers reset high so a level already present at release is not an event.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         estado_reg    <= JOGANDO;
         pontos_reg    <= '0;
         vidas_reg     <= VIDAS_INI;
         timer_reg     <= '0;
         inimigo_q_reg <= 1'b1;
         nave_q_reg    <= 1'b1;
      end else begin
         estado_reg    <= estado_next;
         pontos_reg    <= pontos_next;
         vidas_reg     <= vidas_next;
         timer_reg     <= timer_next;
         inimigo_q_reg <= bus.acerto_inimigo;
         nave_q_reg    <= bus.acerto_nave;
      end
   end

   always_comb begin
      estado_next = estado_reg;
      pontos_next = pontos_reg;
      vidas_next  = vidas_reg;
      timer_next  = timer_reg;
      if (!bus.pausa) begin
         if (ev_inimigo && (estado_reg != PERDEU))
            pontos_next = bcd_soma_sat(pontos_reg, PONTOS_INC);
         case (estado_reg)
            JOGANDO: begin
               if (ev_nave) begin
                  vidas_next = vidas_reg - 4'd1;
                  if (vidas_reg == 4'd1) begin
                     estado_next = PERDEU;
                  end else begin
                     estado_next = INVULNERAVEL;
                     timer_next  = TIMER_INI;
                  end
               end
            end
            INVULNERAVEL: begin
               if (timer_reg == '0)
                  estado_next = JOGANDO;
               else
                  timer_next = timer_reg - TW'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.pontos       = pontos_reg;
   assign bus.vidas        = vidas_reg;
   assign bus.perdeu       = (estado_reg == PERDEU);
   assign bus.invulneravel = (estado_reg == INVULNERAVEL);

`ifdef PLACAR_PISCA_EN
   localparam int            PW       = $clog2(PISCA_CICLOS + 1);
   localparam logic [PW-1:0] PISCA_FIM = PW'(PISCA_CICLOS - 1);

   logic [PW-1:0] pisca_cnt_reg;
   logic          pisca_reg;

   // Blink phase restarts dark-off (digits visible) every time PERDEU is entered.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         pisca_cnt_reg <= '0;
         pisca_reg     <= 1'b0;
      end else if (estado_reg != PERDEU) begin
         pisca_cnt_reg <= '0;
         pisca_reg     <= 1'b0;
      end else if (!bus.pausa) begin
         if (pisca_cnt_reg == PISCA_FIM) begin
            pisca_cnt_reg <= '0;
            pisca_reg     <= ~pisca_reg;
         end else begin
            pisca_cnt_reg <= pisca_cnt_reg + PW'(1);
         end
      end
   end

   assign apagar = pisca_reg;
`else
   assign apagar = 1'b0;
`endif

   // Digit 4 is fed a non-decimal code so its decoder yields a blank display.
   logic [3:0] digito [6];
   logic [6:0] seg    [6];

   assign digito[0] = pontos_reg[3:0];
   assign digito[1] = pontos_reg[7:4];
   assign digito[2] = pontos_reg[11:8];
   assign digito[3] = pontos_reg[15:12];
   assign digito[4] = 4'hF;
   assign digito[5] = vidas_reg;

   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_dec
         bcd_para_7seg u_dec (
            .bcd (digito[gi]),
            .seg (seg[gi])
         );
      end
   endgenerate

   assign HEX0 = apagar ? SEG_BLANK : seg[0];
   assign HEX1 = apagar ? SEG_BLANK : seg[1];
   assign HEX2 = apagar ? SEG_BLANK : seg[2];
   assign HEX3 = apagar ? SEG_BLANK : seg[3];
   assign HEX4 = apagar ? SEG_BLANK : seg[4];
   assign HEX5 = apagar ? SEG_BLANK : seg[5];

endmodule

// File: tb/tb_placar_hex.sv
// Self-checking bench for placar_hex: directed scenarios plus random play against a behavioural model.
module tb_placar_hex;

   localparam int INV = 8;

   logic       clk;
   logic       reset;
   logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

   placar_hex_if bus();

   placar_hex #(
      .VIDAS_INICIAIS    (3),
      .PONTOS_POR_ACERTO (1),
      .INVULN_CICLOS     (INV),
      .PISCA_CICLOS      (4)
   ) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .bus      (bus),
      .HEX0     (hex0),
      .HEX1     (hex1),
      .HEX2     (hex2),
      .HEX3     (hex3),
      .HEX4     (hex4),
      .HEX5     (hex5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 0;

   logic [6:0] seg_tab [10];

   // Behavioural model: plain integers for score, lives and remaining protected cycles.
   int m_score, m_lives, m_inv;
   bit m_over, m_ai_q, m_nv_q;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_score = 0;
         m_lives = 3;
         m_inv   = 0;
         m_over  = 0;
         m_ai_q  = 1;
         m_nv_q  = 1;
      end else begin
         bit evi, evn;
         evi = bus.acerto_inimigo && !m_ai_q;
         evn = bus.acerto_nave && !m_nv_q;
         m_ai_q = bus.acerto_inimigo;
         m_nv_q = bus.acerto_nave;
         if (!bus.pausa && !m_over) begin
            if (evi)
               m_score = (m_score + 1 > 9999) ? 9999 : m_score + 1;
            if (m_inv > 0) begin
               m_inv = m_inv - 1;
            end else if (evn) begin
               m_lives = m_lives - 1;
               if (m_lives == 0) m_over = 1;
               else              m_inv  = INV;
            end
         end
      end
   end

   function automatic logic [15:0] bcd16(input int s);
      return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
   endfunction

   task automatic check(input string nome, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h at %0t", nome, got, exp, $time);
      else
         n_pass++;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         logic [63:0] got, exp;
         got = {bus.pontos, bus.vidas, bus.perdeu, bus.invulneravel,
                hex5, hex4, hex3, hex2, hex1, hex0};
         exp = {bcd16(m_score), 4'(m_lives), m_over, (m_inv > 0),
                seg_tab[m_lives], 7'h7F,
                seg_tab[(m_score / 1000) % 10], seg_tab[(m_score / 100) % 10],
                seg_tab[(m_score / 10) % 10], seg_tab[m_score % 10]};
         check("ciclo", got, exp);
      end
   end

   task automatic pulso(input bit inim, input bit nave);
      @(posedge clk); #1;
      if (inim) bus.acerto_inimigo = 1'b1;
      if (nave) bus.acerto_nave    = 1'b1;
      @(posedge clk); #1;
      bus.acerto_inimigo = 1'b0;
      bus.acerto_nave    = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
      seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
      seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;

      bus.pausa = 1'b0;
      bus.acerto_inimigo = 1'b1;
      bus.acerto_nave = 1'b0;
      reset = 1'b1;
      #2 chk_en = 1;

      $display("step: reset release with acerto_inimigo held high");
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_pontos", 64'(bus.pontos), 64'h0000);
      check("reset_hex5", 64'(hex5), 64'h30);
      check("reset_vidas", 64'(bus.vidas), 64'd3);
      bus.acerto_inimigo = 1'b0;
      pulso(1, 0);
      check("primeiro_ponto", 64'(bus.pontos), 64'h0001);

      $display("step: carry to 0010");
      repeat (9) pulso(1, 0);
      check("carry_pontos", 64'(bus.pontos), 64'h0010);
      check("carry_hex1", 64'(hex1), 64'h79);
      check("carry_hex0", 64'(hex0), 64'h40);

      $display("step: pause during invulnerability");
      pulso(0, 1);
      check("hit_vidas", 64'(bus.vidas), 64'd2);
      check("hit_inv", 64'(bus.invulneravel), 64'd1);
      bus.pausa = 1'b1;
      bus.acerto_inimigo = 1'b1;
      bus.acerto_nave = 1'b1;
      repeat (20) @(posedge clk);
      #1 bus.pausa = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("pausa_pontos", 64'(bus.pontos), 64'h0010);
      check("pausa_vidas", 64'(bus.vidas), 64'd2);
      bus.acerto_inimigo = 1'b0;
      bus.acerto_nave = 1'b0;
      repeat (5) @(posedge clk);
      #1 check("pausa_inv_ainda", 64'(bus.invulneravel), 64'd1);
      @(posedge clk);
      #1 check("pausa_inv_fim", 64'(bus.invulneravel), 64'd0);

      $display("step: async reset mid-window");
      pulso(0, 1);
      check("hit2_vidas", 64'(bus.vidas), 64'd1);
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("areset_pontos", 64'(bus.pontos), 64'h0000);
      check("areset_vidas", 64'(bus.vidas), 64'd3);
      check("areset_inv", 64'(bus.invulneravel), 64'd0);
      check("areset_perdeu", 64'(bus.perdeu), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      $display("step: invulnerability window and game over");
      repeat (5) pulso(1, 0);
      pulso(0, 1);
      check("w_vidas", 64'(bus.vidas), 64'd2);
      @(posedge clk);
      @(posedge clk);
      #1 bus.acerto_nave = 1'b1;
      @(posedge clk);
      #1 bus.acerto_nave = 1'b0;
      check("w_ignorado", 64'(bus.vidas), 64'd2);
      repeat (4) @(posedge clk);
      #1 check("w_inv_ainda", 64'(bus.invulneravel), 64'd1);
      @(posedge clk);
      #1 check("w_inv_fim", 64'(bus.invulneravel), 64'd0);
      pulso(0, 1);
      check("w_vidas1", 64'(bus.vidas), 64'd1);
      repeat (8) @(posedge clk);
      pulso(1, 1);
      check("fim_pontos", 64'(bus.pontos), 64'h0006);
      check("fim_perdeu", 64'(bus.perdeu), 64'd1);
      check("fim_vidas", 64'(bus.vidas), 64'd0);
      pulso(1, 0);
      pulso(0, 1);
      check("congelado_pontos", 64'(bus.pontos), 64'h0006);
      check("congelado_vidas", 64'(bus.vidas), 64'd0);

      $display("step: saturation at 9999");
      do_reset();
      repeat (9998) pulso(1, 0);
      check("sat_9998", 64'(bus.pontos), 64'h9998);
      repeat (3) pulso(1, 0);
      check("sat_9999", 64'(bus.pontos), 64'h9999);
      check("sat_hex3", 64'(hex3), 64'h10);

      $display("step: random play");
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #1;
         if ($urandom_range(0, 399) == 0) begin
            reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
         end
         bus.pausa          = ($urandom_range(0, 7) == 0);
         bus.acerto_inimigo = $urandom_range(0, 1) == 1;
         bus.acerto_nave    = ($urandom_range(0, 5) == 0);
      end

      @(negedge clk);
      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/placar_hex.md
Name: placar_hex

Overview:
- Score and lives keeper that sits downstream of the entities stage.
- Consumes the collision events from entities: allied ball hits enemy, and enemy ball hits ship.
- Maintains a 4-digit BCD score, a lives counter and the game-over flag.
- Drives the six seven-segment displays and feeds `perdeu` back to the tela stage.

Parameters:
- VIDAS_INICIAIS, 3, lives loaded at reset; legal range 1..9.
- PONTOS_POR_ACERTO, 1, BCD points added per enemy hit; legal range 1..9.
- INVULN_CICLOS, 50_000_000, invulnerability window after losing a life, in clock cycles; must be ≥2.
- PISCA_CICLOS, 12_500_000, half-period of the game-over blink, in clock cycles (used only with the optional feature).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- pausa  in  1  freezes all scoring, life loss and timers.
- acerto_inimigo  in  1  level from entities: allied ball overlaps a live enemy.
- acerto_nave  in  1  level from entities: enemy ball overlaps the ship.
- pontos  out  16  score as 4 BCD digits; [15:12] is the thousands digit.
- vidas  out  4  remaining lives, 0..9.
- perdeu  out  1  game over; to tela.
- invulneravel  out  1  high while the post-hit window is active.
- HEX0..HEX5  out  7 each  active-low segments {g,f,e,d,c,b,a}.

Behaviour:
- Reset (asynchronous, active-high). All outputs and registers return to reset values, whether or not a game is in progress:
  - pontos=0000, vidas=VIDAS_INICIAIS, perdeu=0, invulneravel=0, state JOGANDO, timers 0.
  - Edge-detect registers reset to 1, so an input already high at reset release does not count as an event.
- Event detection, per input: ev = in & ~in_q, where in_q is the previous-cycle value. in_q updates every cycle, including during pausa. A rising edge that occurs while pausa=1 is therefore lost, not deferred.
- Latency: all outputs are registered. The rising edge is sampled at edge k; pontos, vidas and state update at edge k. HEX outputs decode those registers combinationally.
- Score, when ev_inimigo and pausa=0 and state≠PERDEU:
  - pontos += PONTOS_POR_ACERTO, with decimal carry through the four digits.
  - If the true sum would exceed 9999, pontos saturates at 9999 (no wrap-around).
  - Score is credited in both JOGANDO and INVULNERAVEL.
- State machine (2-bit):
  - JOGANDO: on ev_nave with pausa=0, vidas decrements.
    - If vidas was 1: go to PERDEU, perdeu=1, vidas=0.
    - Otherwise: go to INVULNERAVEL, timer=INVULN_CICLOS-1.
  - INVULNERAVEL: invulneravel=1 and ev_nave is ignored. The timer decrements each cycle while pausa=0 and holds while pausa=1. On the cycle the timer reads 0, the next state is JOGANDO.
  - PERDEU: terminal. perdeu=1; all events are ignored; pontos and vidas are frozen. Only reset exits this state.
- Simultaneous ev_inimigo and ev_nave in one cycle: both take effect. The score is credited even if the same hit ends the game.
- Displays:
  - HEX0..HEX3 show units..thousands of pontos, with leading zeros shown.
  - HEX4 is blank (7'h7F).
  - HEX5 shows vidas.
  - Digits above 9 never occur.

Optional Feature:
- Macro: PLACAR_PISCA_EN.
- Defined:
  - In PERDEU, a counter toggles a blink bit every PISCA_CICLOS cycles.
  - While the bit is 1, HEX0..HEX5 are all blank; while it is 0, they show the normal digits.
  - The bit starts at 0 on entry to PERDEU.
  - The counter is cleared by reset and in every other state.
- Not defined: no blink counter is built, and the displays are steady in PERDEU.

Decomposition:
- Shared package placar_pkg:
  - State encoding: JOGANDO=2'd0, INVULNERAVEL=2'd1, PERDEU=2'd2.
  - Segment constants: SEG_BLANK=7'h7F, plus the 0..9 patterns.
  - Parameter legality checks.
- One sub-module, bcd_para_7seg: 4-bit BCD in → 7-bit active-low segments out, purely combinational. It is instantiated six times.

Test Plan (bench uses INVULN_CICLOS=8, PISCA_CICLOS=4):
- Reset release with acerto_inimigo held high → pontos stays 0000 and HEX5 shows "3". Input low then high → pontos 0001 one edge later.
- 10 enemy edges with P=1 → pontos 0010 (carry), HEX1="1", HEX0="0". Preload to 9998, then 3 edges → 9999 held.
- acerto_nave edge → vidas 2 and invulneravel=1. A second edge 3 cycles later → still 2. Exactly 8 cycles after the hit invulneravel=0; the next edge → vidas 1.
- Third life lost → perdeu=1, vidas 0. Further enemy/ship edges → pontos and vidas unchanged.
- Both edges in the same cycle on the last life → pontos +1 and perdeu=1 at the same edge.
- pausa=1 during invulnerability for 20 cycles → timer frozen, window extends by 20. Edge during pausa → ignored. Async reset mid-window → all reset values immediately, without a clock edge.
